// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM host-port arbiter.
// Address/data defaults mirror the SDRAM controller parameter header.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } arb_state_e;

    localparam int ARB_ASIZE = 23;
    localparam int ARB_DSIZE = 16;
    localparam int WDOG_W    = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after last_winner wins.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_winner,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    int   p;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        p     = 0;
        for (int off = 1; off <= N; off++) begin
            p = int'(last_winner) + off;
            if (p >= N) p = p - N;
            if (!found && req[p]) begin
                gnt[p] = 1'b1;
                idx    = IW'(p);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_host_arbiter.sv
// Serialises whole burst transactions from NUM_PORTS clients onto the single
// SDRAM controller host port, with level WR/RD, a forced idle gap and a watchdog.
module sdram_host_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int ASIZE      = ARB_ASIZE,
    parameter int DSIZE      = ARB_DSIZE,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic                       REF_CLK,
    input  logic                       RESET_N,
    input  logic [NUM_PORTS-1:0]       REQ,
    input  logic [NUM_PORTS-1:0]       REQ_WR,
    input  logic [NUM_PORTS*ASIZE-1:0] REQ_ADDR,
    input  logic [NUM_PORTS*8-1:0]     REQ_LEN,
    input  logic [NUM_PORTS*DSIZE-1:0] REQ_WDATA,
    output logic [NUM_PORTS-1:0]       GNT,
    output logic [NUM_PORTS-1:0]       ACK,
    output logic [NUM_PORTS-1:0]       ERR,
    output logic [NUM_PORTS-1:0]       PORT_IN_REQ,
    output logic [NUM_PORTS-1:0]       PORT_OUT_VALID,
    output logic                       BUSY,
    output logic [ASIZE-1:0]           ADDR,
    output logic [7:0]                 LENGTH,
    output logic                       WR,
    output logic                       RD,
    output logic [DSIZE-1:0]           DATAIN,
    input  logic                       DONE,
    input  logic                       IN_REQ,
    input  logic                       OUT_VALID
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
    localparam logic [7:0]        GAP_LOAD   = 8'(GAP_CYCLES - 1);

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic [ASIZE-1:0]     addr_q, addr_d;
    logic [7:0]           len_q, len_d, gap_q, gap_d;
    logic                 dir_q, dir_d, wr_q, wr_d, rd_q, rd_d;
    logic [IW-1:0]        last_q, last_d;
    logic [WDOG_W-1:0]    wdog_q, wdog_d;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [IW-1:0]        pick_idx;
    logic [7:0]           pick_len;

    rr_picker #(.N(NUM_PORTS), .IW(IW)) u_picker (
        .req         (REQ),
        .last_winner (last_q),
        .gnt         (pick_gnt),
        .idx         (pick_idx)
    );

    assign pick_len = REQ_LEN[pick_idx*8 +: 8];

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        len_d   = len_q;
        dir_d   = dir_q;
        last_d  = last_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        wdog_d  = wdog_q;
        gap_d   = gap_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            ST_IDLE: if (|REQ) begin
                gnt_d   = pick_gnt;
                addr_d  = REQ_ADDR[pick_idx*ASIZE +: ASIZE];
                len_d   = (pick_len == 8'd0) ? 8'd1 : pick_len;
                dir_d   = REQ_WR[pick_idx];
                last_d  = pick_idx;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                wr_d    = dir_q;
                rd_d    = ~dir_q;
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // DONE is checked first so a completion on the timeout edge still ACKs
                if (DONE) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    ack_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end else if (wdog_q == WDOG_LIMIT) begin
                    wr_d    = 1'b0;
                    rd_d    = 1'b0;
                    err_d   = gnt_q;
                    gnt_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    wdog_d  = wdog_q + WDOG_W'(1);
                end
            end
            ST_RELEASE: if (!DONE) begin
                gap_d   = GAP_LOAD;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge REF_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            dir_q   <= 1'b0;
            last_q  <= IW'(NUM_PORTS - 1);
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wdog_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wdog_q  <= wdog_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        DATAIN = '0;
        for (int i = 0; i < NUM_PORTS; i++)
            if (gnt_q[i]) DATAIN = DATAIN | REQ_WDATA[i*DSIZE +: DSIZE];
    end

    assign GNT            = gnt_q;
    assign ACK            = ack_q;
    assign ERR            = err_q;
    assign ADDR           = addr_q;
    assign LENGTH         = len_q;
    assign WR             = wr_q;
    assign RD             = rd_q;
    assign BUSY           = (state_q != ST_IDLE);
    assign PORT_IN_REQ    = gnt_q & {NUM_PORTS{IN_REQ}};
    assign PORT_OUT_VALID = gnt_q & {NUM_PORTS{OUT_VALID}};

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// Directed bench for sdram_host_arbiter with a hand-driven controller DONE.
module tb_sdram_host_arbiter;

    localparam int NP = 4;
    localparam int AW = 23;
    localparam int DW = 16;

    logic            REF_CLK = 1'b0;
    logic            RESET_N;
    logic [NP-1:0]   REQ, REQ_WR;
    logic [NP*AW-1:0] REQ_ADDR;
    logic [NP*8-1:0]  REQ_LEN;
    logic [NP*DW-1:0] REQ_WDATA;
    logic [NP-1:0]   GNT, ACK, ERR, PORT_IN_REQ, PORT_OUT_VALID;
    logic            BUSY, WR, RD, DONE, IN_REQ, OUT_VALID;
    logic [AW-1:0]   ADDR;
    logic [7:0]      LENGTH;
    logic [DW-1:0]   DATAIN;

    int tests_run    = 0;
    int tests_failed = 0;

    sdram_host_arbiter #(
        .NUM_PORTS(NP), .ASIZE(AW), .DSIZE(DW), .GAP_CYCLES(2), .TIMEOUT(15)
    ) dut (
        .REF_CLK(REF_CLK), .RESET_N(RESET_N), .REQ(REQ), .REQ_WR(REQ_WR),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN), .REQ_WDATA(REQ_WDATA),
        .GNT(GNT), .ACK(ACK), .ERR(ERR), .PORT_IN_REQ(PORT_IN_REQ),
        .PORT_OUT_VALID(PORT_OUT_VALID), .BUSY(BUSY), .ADDR(ADDR),
        .LENGTH(LENGTH), .WR(WR), .RD(RD), .DATAIN(DATAIN), .DONE(DONE),
        .IN_REQ(IN_REQ), .OUT_VALID(OUT_VALID)
    );

    always #5 REF_CLK = ~REF_CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge REF_CLK);
        #1;
    endtask

    task automatic set_port(input int p, input logic [AW-1:0] a, input logic [7:0] l,
                            input logic [DW-1:0] w);
        REQ_ADDR[p*AW +: AW]  = a;
        REQ_LEN[p*8 +: 8]     = l;
        REQ_WDATA[p*DW +: DW] = w;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY && n < 50) begin tick(); n++; end
        check("wait_idle", 64'(n < 50), 64'(1));
    endtask

    task automatic wait_cmd();
        int n = 0;
        while (!(WR || RD) && n < 60) begin tick(); n++; end
        check("wait_cmd", 64'(n < 60), 64'(1));
    endtask

    // Waits for WR/RD, checks the presented command, then completes it with DONE.
    task automatic run_txn(input int port, input logic [AW-1:0] a, input logic [7:0] l,
                           input logic d);
        logic [NP-1:0] oh;
        oh = NP'(1) << port;
        wait_cmd();
        check("txn_gnt", 64'(GNT), 64'(oh));
        check("txn_addr", 64'(ADDR), 64'(a));
        check("txn_len", 64'(LENGTH), 64'(l));
        check("txn_wr", 64'(WR), 64'(d));
        check("txn_rd", 64'(RD), 64'(!d));
        repeat (2) tick();
        DONE = 1'b1;
        tick();
        check("txn_ack", 64'(ACK), 64'(oh));
        check("txn_cmd_low", 64'(WR | RD), 64'(0));
        DONE = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        RESET_N = 1'b0; REQ = '0; REQ_WR = '0; REQ_ADDR = '0; REQ_LEN = '0;
        REQ_WDATA = '0; DONE = 1'b0; IN_REQ = 1'b0; OUT_VALID = 1'b0;
        repeat (2) tick();
        check("rst_gnt", 64'(GNT), 64'(0));
        check("rst_wrrd", 64'({WR, RD}), 64'(0));
        check("rst_addr", 64'(ADDR), 64'(0));
        check("rst_len", 64'(LENGTH), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_ackerr", 64'({ACK, ERR}), 64'(0));
        check("rst_datain", 64'(DATAIN), 64'(0));
        RESET_N = 1'b1;
        tick();

        // Single read on port 0
        set_port(0, 23'h000100, 8'd8, 16'h1111);
        REQ_WR = 4'b0000;
        REQ = 4'b0001;
        tick();
        check("sr_gnt", 64'(GNT), 64'(4'b0001));
        check("sr_addr", 64'(ADDR), 64'(23'h000100));
        check("sr_len", 64'(LENGTH), 64'(8));
        check("sr_rd_not_yet", 64'(RD), 64'(0));
        check("sr_busy", 64'(BUSY), 64'(1));
        REQ = 4'b0000;
        tick();
        check("sr_rd", 64'(RD), 64'(1));
        check("sr_wr", 64'(WR), 64'(0));
        OUT_VALID = 1'b1;
        #1;
        check("sr_pov", 64'(PORT_OUT_VALID), 64'(4'b0001));
        OUT_VALID = 1'b0;
        repeat (8) tick();
        check("sr_hold", 64'(RD), 64'(1));
        DONE = 1'b1;
        tick();
        check("sr_rd_drop", 64'(RD), 64'(0));
        check("sr_ack", 64'(ACK), 64'(4'b0001));
        check("sr_gnt_clr", 64'(GNT), 64'(0));
        check("sr_no_err", 64'(ERR), 64'(0));
        DONE = 1'b0;
        tick();
        check("sr_ack_pulse", 64'(ACK), 64'(0));
        check("sr_busy_gap", 64'(BUSY), 64'(1));
        repeat (2) tick();
        check("sr_idle", 64'(BUSY), 64'(0));

        // Round robin from a fresh reset so port 0 leads; port 3 has LEN=0
        RESET_N = 1'b0;
        tick();
        for (int p = 0; p < NP; p++)
            set_port(p, AW'(32'h1000 * (p + 1)), (p == 3) ? 8'd0 : 8'(p + 3), 16'(p));
        REQ_WR = 4'b1010;
        REQ = 4'b1111;
        RESET_N = 1'b1;
        for (int t = 0; t < 8; t++) begin
            int p;
            p = t % NP;
            run_txn(p, AW'(32'h1000 * (p + 1)), (p == 3) ? 8'd1 : 8'(p + 3), REQ_WR[p]);
        end
        REQ = 4'b0000;
        wait_idle();

        // Write routing on port 2
        set_port(0, 23'h0, 8'd1, 16'h1234);
        set_port(1, 23'h0, 8'd1, 16'h5678);
        set_port(2, 23'h002222, 8'd4, 16'hBEEF);
        set_port(3, 23'h0, 8'd1, 16'h9ABC);
        REQ_WR = 4'b0100;
        REQ = 4'b0100;
        tick();
        check("wr_gnt", 64'(GNT), 64'(4'b0100));
        check("wr_datain", 64'(DATAIN), 64'(16'hBEEF));
        check("wr_len", 64'(LENGTH), 64'(4));
        REQ = 4'b0000;
        tick();
        check("wr_wr", 64'(WR), 64'(1));
        IN_REQ = 1'b1;
        #1;
        check("wr_pir", 64'(PORT_IN_REQ), 64'(4'b0100));
        IN_REQ = 1'b0;
        tick();
        DONE = 1'b1;
        tick();
        check("wr_ack", 64'(ACK), 64'(4'b0100));
        check("wr_datain_clr", 64'(DATAIN), 64'(0));
        DONE = 1'b0;
        wait_idle();

        // Watchdog: port 0 never completes, port 1 is served next
        set_port(0, 23'h003000, 8'd2, 16'h0);
        set_port(1, 23'h004000, 8'd6, 16'h0);
        REQ_WR = 4'b0000;
        REQ = 4'b0011;
        tick();
        check("wd_gnt", 64'(GNT), 64'(4'b0001));
        tick();
        check("wd_rd", 64'(RD), 64'(1));
        repeat (15) tick();
        check("wd_still_rd", 64'(RD), 64'(1));
        check("wd_no_err_yet", 64'(ERR), 64'(0));
        tick();
        check("wd_err", 64'(ERR), 64'(4'b0001));
        check("wd_rd_drop", 64'(RD), 64'(0));
        check("wd_no_ack", 64'(ACK), 64'(0));
        check("wd_gnt_clr", 64'(GNT), 64'(0));
        tick();
        check("wd_err_pulse", 64'(ERR), 64'(0));
        run_txn(1, 23'h004000, 8'd6, 1'b0);
        REQ = 4'b0000;
        wait_idle();

        // Gap/edge: DONE lingers 5 cycles after the write drops
        begin
            int n;
            REQ_WR = 4'b0001;
            REQ = 4'b0001;
            wait_cmd();
            check("ge_wr", 64'(WR), 64'(1));
            repeat (2) tick();
            DONE = 1'b1;
            tick();
            check("ge_ack", 64'(ACK), 64'(4'b0001));
            repeat (5) tick();
            check("ge_hold", 64'({BUSY, WR, GNT}), 64'({1'b1, 1'b0, 4'b0000}));
            DONE = 1'b0;
            n = 0;
            while (!WR && n < 20) begin tick(); n++; end
            check("ge_spacing", 64'(n), 64'(5));
            tick();
            DONE = 1'b1;
            REQ = 4'b0000;
            tick();
            DONE = 1'b0;
            wait_idle();
        end

        // Reset mid-burst
        REQ_WR = 4'b0000;
        REQ = 4'b0100;
        wait_cmd();
        repeat (3) tick();
        RESET_N = 1'b0;
        #1;
        check("mr_gnt", 64'(GNT), 64'(0));
        check("mr_wrrd", 64'({WR, RD}), 64'(0));
        check("mr_busy", 64'(BUSY), 64'(0));
        check("mr_addr_len", 64'({ADDR, LENGTH}), 64'(0));
        check("mr_datain", 64'(DATAIN), 64'(0));
        REQ = 4'b0101;
        tick();
        RESET_N = 1'b1;
        tick();
        check("mr_first_gnt", 64'(GNT), 64'(4'b0001));
        REQ = 4'b0000;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/sdram_host_arbiter.md
# sdram_host_arbiter

Round-robin arbiter that shares the single host port of the SDRAM controller (ADDR/WR/RD/LENGTH/DONE/IN_REQ/OUT_VALID/DATAIN) between NUM_PORTS requesters, e.g. video read FIFOs and capture write FIFOs. It serialises whole burst transactions, generates the level-held WR/RD handshake the controller expects, and enforces a minimum idle gap so every new request presents a clean rising edge. It also runs a watchdog so one hung transaction cannot lock the port. It sits in the REF_CLK domain between the client FIFOs and the SDRAM controller.

## Interface
- NUM_PORTS, 4: number of requesters (2..8)
- ASIZE, 23: address width (matches controller)
- DSIZE, 16: data width
- GAP_CYCLES, 2: idle cycles forced between transactions (>=1)
- TIMEOUT, 1023: cycles in WAIT before abort (<=65535)

- REF_CLK  in  1  sole clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- REQ  in  NUM_PORTS  per-port level request
- REQ_WR  in  NUM_PORTS  1=write, 0=read; sampled at grant
- REQ_ADDR  in  NUM_PORTS*ASIZE  per-port start address, port i at [i*ASIZE +: ASIZE]
- REQ_LEN  in  NUM_PORTS*8  per-port burst length
- REQ_WDATA  in  NUM_PORTS*DSIZE  per-port write data
- GNT  out  NUM_PORTS  one-hot grant, held for the whole transaction
- ACK  out  NUM_PORTS  1-cycle pulse: transaction completed
- ERR  out  NUM_PORTS  1-cycle pulse: transaction aborted by watchdog
- PORT_IN_REQ  out  NUM_PORTS  IN_REQ routed to granted port (combinational AND with GNT)
- PORT_OUT_VALID  out  NUM_PORTS  OUT_VALID routed to granted port (combinational AND with GNT)
- BUSY  out  1  high whenever state != IDLE
- ADDR  out  ASIZE  to controller
- LENGTH  out  8  to controller
- WR, RD  out  1 each  to controller, level, never both high
- DATAIN  out  DSIZE  REQ_WDATA slice of granted port; 0 when no grant
- DONE  in  1  from controller
- IN_REQ, OUT_VALID  in  1 each  from controller

## Operation
- States: IDLE, ISSUE, WAIT, RELEASE, GAP.
- IDLE: if any REQ bit is set, pick the winner with rr_picker. Search starts at (last_winner+1) mod NUM_PORTS, wraps around, first set bit wins. Register GNT, ADDR, LENGTH, dir and last_winner, then go to ISSUE. REQ_LEN of 0 is forwarded as 1.
- ISSUE: drive WR (dir=1) or RD (dir=0) high, clear the watchdog counter, go to WAIT.
- WAIT: hold WR/RD. If DONE=1, drop WR/RD, pulse ACK[winner], clear GNT, go to RELEASE. Otherwise, when the counter reaches TIMEOUT, drop WR/RD, pulse ERR[winner], clear GNT, go to RELEASE.
- RELEASE: wait for DONE=0. Then load the gap counter with GAP_CYCLES-1 and go to GAP.
- GAP: count down to 0, then go to IDLE.
- Deasserting REQ during a transaction has no effect; the burst completes. Requests arriving in any non-IDLE state wait for IDLE.
- A port holding REQ high continuously is re-arbitrated each time, so other requesters are never starved: worst-case wait is NUM_PORTS-1 transactions.
- ADDR, LENGTH and direction are stable from the cycle before WR/RD rises until after they fall.

## Timing
- Reset values: GNT=0, ACK=0, ERR=0, WR=0, RD=0, ADDR=0, LENGTH=0, BUSY=0, state=IDLE, last_winner=NUM_PORTS-1 so port 0 wins first. DATAIN and the PORT_* outputs are 0 because GNT=0.
- Latency:
  - REQ sampled high at edge k (IDLE): GNT/ADDR/LENGTH valid after edge k.
  - WR/RD high after edge k+1.
  - DONE sampled high at edge m: WR/RD low and ACK high after edge m; ACK low after edge m+1.
- Minimum back-to-back spacing: WR/RD low for at least 1 (RELEASE) + GAP_CYCLES + 2 cycles.
- Watchdog: a 16-bit counter increments every WAIT cycle. Abort occurs on the edge where the count equals TIMEOUT, i.e. TIMEOUT+1 cycles after WR/RD rose.
- DONE and timeout in the same cycle: DONE wins (ACK, no ERR).
- Reset asserted mid-transaction: all outputs clear asynchronously. The controller sees WR/RD low, and its DONE clears under its own rule.

## Structure
- Package sdram_arb_pkg holds:
  - the state enum (5 states, 3-bit encoding);
  - the ASIZE/DSIZE defaults, kept equal to the controller parameter header;
  - the watchdog counter width constant (16).
- Sub-module rr_picker (inputs: req vector and last_winner; outputs: one-hot grant and encoded index) is purely combinational. It is reused by other team arbiters.
- The top level contains the FSM, the counters, the registered command outputs and the data/handshake muxing.

## Test plan
- Single read: REQ=0001, REQ_WR=0, ADDR0=0x000100, LEN0=8. RD rises 2 cycles after REQ; DONE stub responds after 20 cycles. Expect ACK[0] pulse, GNT back to 0, PORT_OUT_VALID only on bit 0.
- Round robin: all four REQ held high for 8 transactions. Grant order is 0,1,2,3,0,1,2,3; each port gets ADDR/LENGTH from its own slice.
- Write routing: port 2 write, LEN=4, REQ_WDATA slice 2 = 0xBEEF. DATAIN=0xBEEF while granted; PORT_IN_REQ=0100 while IN_REQ is high.
- Watchdog: TIMEOUT=15, DONE stub never responds. ERR[winner] pulses 16 cycles after RD rose; WR/RD drop; no ACK; the next port is served.
- Gap/edge: controller DONE held high 5 extra cycles after WR drop. The arbiter stays in RELEASE, then spends GAP_CYCLES=2 in GAP. The next WR rises no earlier than 4 cycles after DONE falls.
- Reset mid-burst: RESET_N low during WAIT. All outputs are 0 immediately. After release, port 0 is granted first.
